// File: rtl/sign_extender_if.sv
// Immediate-extension bus between the decoder (master) and the sign extender (slave).
interface sign_extender_if #(
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned OUT_WIDTH = 16
) ();

   logic [IN_WIDTH-1:0]  data;
   logic                 in_valid;
   logic                 zeroExtend;
   logic [1:0]           scale;
   logic [OUT_WIDTH-1:0] extendedData;
   logic                 out_valid;
   logic                 isNegative;

   modport master (
      output data,
      output in_valid,
      output zeroExtend,
      output scale,
      input  extendedData,
      input  out_valid,
      input  isNegative
   );

   modport slave (
      input  data,
      input  in_valid,
      input  zeroExtend,
      input  scale,
      output extendedData,
      output out_valid,
      output isNegative
   );

endinterface

// File: rtl/sign_extender.sv
// Registered sign/zero extender with optional left scale by 0..3; one pipeline stage,
// always ready. Data and sign flag hold while in_valid is low; out_valid tracks in_valid.
module sign_extender #(
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned OUT_WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   sign_extender_if.slave bus
);

   // Three spare MSBs keep a scale of 3 from dropping any significant bit.
   if (IN_WIDTH < 2 || IN_WIDTH > 16) begin : g_bad_in_width
      $error("sign_extender: IN_WIDTH must be in 2..16");
   end
   if (OUT_WIDTH < IN_WIDTH + 3) begin : g_bad_out_width
      $error("sign_extender: OUT_WIDTH must be at least IN_WIDTH + 3");
   end
   if ($bits(bus.data) != IN_WIDTH || $bits(bus.extendedData) != OUT_WIDTH) begin : g_bad_bus
      $error("sign_extender: interface widths do not match module parameters");
   end

   localparam int unsigned PadWidth = OUT_WIDTH - IN_WIDTH;

   logic [OUT_WIDTH-1:0] w_ext;
   logic [OUT_WIDTH-1:0] w_result;
   logic                 w_fill;

   logic [OUT_WIDTH-1:0] r_data;
   logic                 r_neg;
   logic                 r_valid;

   always_comb begin
      w_fill   = bus.zeroExtend ? 1'b0 : bus.data[IN_WIDTH-1];
      w_ext    = {{PadWidth{w_fill}}, bus.data};
      w_result = w_ext << bus.scale;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_neg   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_data <= w_result;
            r_neg  <= w_result[OUT_WIDTH-1];
         end
      end
   end

   assign bus.extendedData = r_data;
   assign bus.isNegative   = r_neg;
   assign bus.out_valid    = r_valid;

endmodule

// File: tb/tb_sign_extender.sv
// Directed-vector bench for sign_extender (IN_WIDTH=4, OUT_WIDTH=16) with
// hand-computed expected results.
module tb_sign_extender;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   sign_extender_if #(.IN_WIDTH(4), .OUT_WIDTH(16)) bus ();

   sign_extender #(
      .IN_WIDTH (4),
      .OUT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  d;
      logic        z;
      logic [1:0]  s;
      logic [15:0] e;
      logic        n;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic z, input logic [1:0] s);
      bus.in_valid   = v;
      bus.data       = d;
      bus.zeroExtend = z;
      bus.scale      = s;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      vecs[0] = '{4'h0, 1'b0, 2'd0, 16'h0000, 1'b0};
      vecs[1] = '{4'h5, 1'b0, 2'd0, 16'h0005, 1'b0};
      vecs[2] = '{4'h9, 1'b0, 2'd0, 16'hFFF9, 1'b1};
      vecs[3] = '{4'hF, 1'b0, 2'd0, 16'hFFFF, 1'b1};
      vecs[4] = '{4'h7, 1'b0, 2'd0, 16'h0007, 1'b0};
      vecs[5] = '{4'h9, 1'b1, 2'd0, 16'h0009, 1'b0};
      vecs[6] = '{4'hF, 1'b1, 2'd0, 16'h000F, 1'b0};
      vecs[7] = '{4'h9, 1'b0, 2'd2, 16'hFFE4, 1'b1};
      vecs[8] = '{4'h7, 1'b0, 2'd3, 16'h0038, 1'b0};
      vecs[9] = '{4'h8, 1'b0, 2'd3, 16'hFFC0, 1'b1};

      // Reset with a valid input pending: input must be dropped.
      rst = 1'b1;
      drive(1'b1, 4'hF, 1'b0, 2'd0);
      step();
      step();
      check("rst_data", 32'(bus.extendedData), 32'h0);
      check("rst_neg", 32'(bus.isNegative), 32'h0);
      check("rst_valid", 32'(bus.out_valid), 32'h0);

      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, vecs[i].d, vecs[i].z, vecs[i].s);
         #1;
         // Before the edge the output must still show the previous result.
         if (i > 0) check($sformatf("pre_%0d", i), 32'(bus.extendedData), 32'(vecs[i-1].e));
         step();
         check($sformatf("data_%0d", i), 32'(bus.extendedData), 32'(vecs[i].e));
         check($sformatf("neg_%0d", i), 32'(bus.isNegative), 32'(vecs[i].n));
         check($sformatf("valid_%0d", i), 32'(bus.out_valid), 32'h1);
      end

      // Hold: result 5 registered, then invalid inputs must not disturb it.
      drive(1'b1, 4'h5, 1'b0, 2'd0);
      step();
      check("hold_load", 32'(bus.extendedData), 32'h0005);
      drive(1'b0, 4'hF, 1'b0, 2'd0);
      step();
      check("hold_data", 32'(bus.extendedData), 32'h0005);
      check("hold_valid", 32'(bus.out_valid), 32'h0);
      check("hold_neg", 32'(bus.isNegative), 32'h0);
      drive(1'b0, 4'bxxxx, 1'b0, 2'd1);
      step();
      check("hold_x_data", 32'(bus.extendedData), 32'h0005);
      check("hold_x_neg", 32'(bus.isNegative), 32'h0);

      // Mid-stream reset pulse.
      drive(1'b1, 4'h3, 1'b0, 2'd0);
      step();
      check("mid_pre_data", 32'(bus.extendedData), 32'h0003);
      check("mid_pre_valid", 32'(bus.out_valid), 32'h1);
      rst = 1'b1;
      drive(1'b1, 4'hE, 1'b0, 2'd0);
      step();
      check("mid_rst_data", 32'(bus.extendedData), 32'h0);
      check("mid_rst_neg", 32'(bus.isNegative), 32'h0);
      check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      rst = 1'b0;
      drive(1'b1, 4'h9, 1'b0, 2'd1);
      step();
      check("mid_post_data", 32'(bus.extendedData), 32'hFFF2);
      check("mid_post_neg", 32'(bus.isNegative), 32'h1);
      check("mid_post_valid", 32'(bus.out_valid), 32'h1);
      drive(1'b0, 4'h0, 1'b0, 2'd0);
      step();
      check("mid_end_valid", 32'(bus.out_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
